// File: rtl/sys_arr_in_streamer.sv
// Streams packed A-column / B-row segments from two fixed-latency banked memories to sys_array.
// Reads are credit-limited so the beat FIFO can never overflow under backpressure.
module sys_arr_in_streamer #(
  parameter  int BW         = 128,
  parameter  int M          = 64,
  parameter  int N          = 4,
  parameter  int MEM_LAT    = 3,
  parameter  int FIFO_DEPTH = 4,
  localparam int L          = BW / 2,
  localparam int TOTAL      = N * M / L,
  localparam int AW         = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              a_rd_en,
  output logic [AW-1:0]     a_rd_addr,
  input  logic [L*32-1:0]   a_rd_data,
  output logic              b_rd_en,
  output logic [AW-1:0]     b_rd_addr,
  input  logic [L*32-1:0]   b_rd_data,
  output logic [BW*32-1:0]  m_stream,
  output logic              m_valid,
  input  logic              m_ready
);

  // state  | meaning
  // IDLE   | waiting for start
  // ISSUE  | issuing reads k=N-1..0, blk=0..M/L-1 as credit allows
  // DRAIN  | all reads issued; waiting for returns and final handshakes
  // DONE   | one-cycle done pulse

  localparam int BLKS = M / L;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int BKW  = (BLKS > 1) ? $clog2(BLKS) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int UW   = CW + 1;
  localparam int HW   = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [KW-1:0]       r_k;
  logic [BKW-1:0]      r_blk;
  logic [MEM_LAT-1:0]  r_vld;
  logic [CW-1:0]       r_count, r_out;
  logic [HW-1:0]       r_hs;
  logic [BW*32-1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wp, r_rp;

  logic                w_rd_en, w_cap, w_pop, w_last, w_credit;
  logic [UW-1:0]       w_used;
  logic [CW-1:0]       w_count_nxt, w_out_nxt;
  logic [HW-1:0]       w_hs_nxt;
  logic [BW*32-1:0]    w_pack;

  assign w_pop       = (r_count != '0) & m_ready;
  assign w_cap       = r_vld[MEM_LAT-1];
  assign w_last      = (r_k == '0) && (r_blk == BKW'(BLKS - 1));
  // A beat leaving this cycle frees its slot, which keeps one beat per cycle when MEM_LAT < FIFO_DEPTH.
  assign w_used      = UW'(r_count) + UW'(r_out) - UW'(w_pop);
  assign w_credit    = w_used < UW'(FIFO_DEPTH);
  assign w_count_nxt = r_count + CW'(w_cap) - CW'(w_pop);
  assign w_out_nxt   = r_out + CW'(w_rd_en) - CW'(w_cap);
  assign w_hs_nxt    = r_hs + HW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (w_credit) begin
          w_rd_en = 1'b1;
          if (w_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_out_nxt == '0 && w_count_nxt == '0 && w_hs_nxt == HW'(TOTAL))
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pack = '0;
    for (int i = 0; i < L; i++) begin
      w_pack[64*i +: 32]      = a_rd_data[32*i +: 32];
      w_pack[64*i + 32 +: 32] = b_rd_data[32*i +: 32];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_blk   <= '0;
      r_vld   <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_hs    <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vld   <= (r_vld << 1) | MEM_LAT'(w_rd_en);
      r_count <= w_count_nxt;
      r_out   <= w_out_nxt;
      if (w_cap) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      if (r_state == S_IDLE && start) begin
        r_k   <= KW'(N - 1);
        r_blk <= '0;
        r_hs  <= '0;
      end else begin
        r_hs <= w_hs_nxt;
        if (w_rd_en && !w_last) begin
          if (r_blk == BKW'(BLKS - 1)) begin
            r_blk <= '0;
            r_k   <= r_k - KW'(1);
          end else begin
            r_blk <= r_blk + BKW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_cap) r_mem[r_wp] <= w_pack;
  end

  assign a_rd_en   = w_rd_en;
  assign b_rd_en   = w_rd_en;
  assign a_rd_addr = AW'(32'(r_k) * BLKS + 32'(r_blk));
  assign b_rd_addr = a_rd_addr;
  assign m_valid   = (r_count != '0);
  assign m_stream  = m_valid ? r_mem[r_rp] : '0;

endmodule

// File: tb/tb_sys_arr_in_streamer.sv
// Directed bench: three streamer instances (MEM_LAT 3, 1, 8) with BW=8, M=8, N=4 behind
// a fixed-latency memory model; index 0 is the main instance, 1 and 2 cover the latency sweep.
module tb_sys_arr_in_streamer;
  localparam int N   = 4;
  localparam int TOT = 8;
  localparam int LATS[3] = '{3, 1, 8};
  localparam logic [2:0] EXP_A[8] = '{3'd6, 3'd7, 3'd4, 3'd5, 3'd2, 3'd3, 3'd0, 3'd1};

  typedef logic [255:0] beat_q_t[$];

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic         start_v[3], rdy_v[3];
  logic         busy_v[3], done_v[3], are_v[3], bre_v[3], mval_v[3];
  logic [2:0]   aaddr_v[3], baddr_v[3];
  logic [127:0] ad_v[3], bd_v[3];
  logic [255:0] ms_v[3];

  sys_arr_in_streamer #(.BW(8), .M(8), .N(4), .MEM_LAT(3), .FIFO_DEPTH(4)) u_lat3 (
    .CLK(CLK), .nRST(nRST), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .a_rd_en(are_v[0]), .a_rd_addr(aaddr_v[0]), .a_rd_data(ad_v[0]),
    .b_rd_en(bre_v[0]), .b_rd_addr(baddr_v[0]), .b_rd_data(bd_v[0]),
    .m_stream(ms_v[0]), .m_valid(mval_v[0]), .m_ready(rdy_v[0]));

  sys_arr_in_streamer #(.BW(8), .M(8), .N(4), .MEM_LAT(1), .FIFO_DEPTH(4)) u_lat1 (
    .CLK(CLK), .nRST(nRST), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .a_rd_en(are_v[1]), .a_rd_addr(aaddr_v[1]), .a_rd_data(ad_v[1]),
    .b_rd_en(bre_v[1]), .b_rd_addr(baddr_v[1]), .b_rd_data(bd_v[1]),
    .m_stream(ms_v[1]), .m_valid(mval_v[1]), .m_ready(rdy_v[1]));

  sys_arr_in_streamer #(.BW(8), .M(8), .N(4), .MEM_LAT(8), .FIFO_DEPTH(4)) u_lat8 (
    .CLK(CLK), .nRST(nRST), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .a_rd_en(are_v[2]), .a_rd_addr(aaddr_v[2]), .a_rd_data(ad_v[2]),
    .b_rd_en(bre_v[2]), .b_rd_addr(baddr_v[2]), .b_rd_data(bd_v[2]),
    .m_stream(ms_v[2]), .m_valid(mval_v[2]), .m_ready(rdy_v[2]));

  function automatic logic [31:0] a_word(input int r, input int c);
    return 32'hA000_0000 | 32'(r << 8) | 32'(c);
  endfunction

  function automatic logic [31:0] b_word(input int r, input int c);
    return 32'hB000_0000 | 32'(r << 8) | 32'(c);
  endfunction

  // Beat n: k = N-1 - n/2, blk = n%2; lanes alternate A[blk*4+i][k], B[k][blk*4+i].
  function automatic logic [255:0] exp_beat(input int n);
    logic [255:0] e;
    int k, blk;
    k   = N - 1 - n / 2;
    blk = n % 2;
    e   = '0;
    for (int i = 0; i < 4; i++) begin
      e[64*i +: 32]      = a_word(blk * 4 + i, k);
      e[64*i + 32 +: 32] = b_word(k, blk * 4 + i);
    end
    return e;
  endfunction

  // Memory model: address pipeline, data presented only at tap MEM_LAT-1, junk otherwise.
  logic       pv[3][8];
  logic [2:0] pa[3][8], pb[3][8];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int d = 0; d < 3; d++)
        for (int s = 0; s < 8; s++) pv[d][s] <= 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        for (int s = 7; s > 0; s--) begin
          pv[d][s] <= pv[d][s-1];
          pa[d][s] <= pa[d][s-1];
          pb[d][s] <= pb[d][s-1];
        end
        pv[d][0] <= are_v[d];
        pa[d][0] <= aaddr_v[d];
        pb[d][0] <= baddr_v[d];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      ad_v[d] = {4{32'hDEAD_BEEF}};
      bd_v[d] = {4{32'hFEED_F00D}};
      if (pv[d][LATS[d]-1]) begin
        for (int i = 0; i < 4; i++) begin
          ad_v[d][32*i +: 32] = a_word((32'(pa[d][LATS[d]-1]) % 2) * 4 + i, 32'(pa[d][LATS[d]-1]) / 2);
          bd_v[d][32*i +: 32] = b_word(32'(pb[d][LATS[d]-1]) / 2, (32'(pb[d][LATS[d]-1]) % 2) * 4 + i);
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  logic [2:0]   sq[$];
  logic [255:0] bq0[$], bq1[$], bq2[$];
  int           str_n, hs_n[3], done_n[3], hs_at_done[3];
  int           first_v, last_hs, done_cyc, maxc, stall_bad, en_bad;
  logic         prev_stall;
  logic [255:0] prev_ms;

  always @(negedge CLK) begin
    if (nRST) begin
      if (str_n - hs_n[0] > maxc) maxc = str_n - hs_n[0];
      if (are_v[0]) begin
        sq.push_back(aaddr_v[0]);
        str_n = str_n + 1;
      end
      if (are_v[0] !== bre_v[0] || aaddr_v[0] !== baddr_v[0]) en_bad = en_bad + 1;
      if (prev_stall && (!mval_v[0] || ms_v[0] !== prev_ms)) stall_bad = stall_bad + 1;
      prev_stall = mval_v[0] && !rdy_v[0];
      prev_ms    = ms_v[0];
      if (mval_v[0] && first_v < 0) first_v = cyc;
      if (mval_v[0] && rdy_v[0]) begin bq0.push_back(ms_v[0]); hs_n[0] = hs_n[0] + 1; last_hs = cyc; end
      if (mval_v[1] && rdy_v[1]) begin bq1.push_back(ms_v[1]); hs_n[1] = hs_n[1] + 1; end
      if (mval_v[2] && rdy_v[2]) begin bq2.push_back(ms_v[2]); hs_n[2] = hs_n[2] + 1; end
      for (int d = 0; d < 3; d++) begin
        if (done_v[d]) begin
          done_n[d]     = done_n[d] + 1;
          hs_at_done[d] = hs_n[d];
          if (d == 0) done_cyc = cyc;
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int t0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    sq.delete(); bq0.delete(); bq1.delete(); bq2.delete();
    str_n = 0; first_v = -1; last_hs = -1; done_cyc = -1;
    maxc = 0; stall_bad = 0; en_bad = 0; prev_stall = 1'b0; prev_ms = '0;
    for (int d = 0; d < 3; d++) begin hs_n[d] = 0; done_n[d] = 0; hs_at_done[d] = -1; end
  endtask

  task automatic wait_done(input int d, input int lim, input string tag);
    int n;
    n = 0;
    while (done_n[d] == 0 && n < lim) begin step(); n++; end
    chk({tag, "_timeout"}, (done_n[d] > 0), 1);
  endtask

  task automatic chk_beats(input string tag, input beat_q_t q);
    chk({tag, "_count"}, q.size(), TOT);
    for (int i = 0; i < q.size() && i < TOT; i++)
      chk($sformatf("%s_beat%0d", tag, i), q[i], exp_beat(i));
  endtask

  task automatic chk_addrs(input string tag);
    chk({tag, "_nstrobe"}, sq.size(), TOT);
    for (int i = 0; i < sq.size() && i < TOT; i++)
      chk($sformatf("%s_addr%0d", tag, i), sq[i], EXP_A[i]);
  endtask

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin start_v[d] = 1'b0; rdy_v[d] = 1'b1; end
    clear_mon();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    chk("rst_rd_en", {are_v[0], bre_v[0]}, 0);
    chk("rst_addr", {aaddr_v[0], baddr_v[0]}, 0);
    chk("rst_valid", mval_v[0], 0);
    chk("rst_stream", ms_v[0], 0);
    nRST = 1'b1;
    step();

    // Free-running ready
    clear_mon();
    t0 = cyc;
    pulse_start(0);
    chk("t1_busy_rise", busy_v[0], 1);
    wait_done(0, 100, "t1");
    repeat (3) step();
    chk_addrs("t1");
    chk("t1_first_valid", first_v - t0, 5);
    chk_beats("t1", bq0);
    chk("t1_last_hs", last_hs - t0, 12);
    chk("t1_done_lag", done_cyc - last_hs, 1);
    chk("t1_done_n", done_n[0], 1);
    chk("t1_b_eq_a", en_bad, 0);
    chk("t1_busy_end", busy_v[0], 0);

    // Ready high one cycle in four
    clear_mon();
    rdy_v[0] = 1'b0;
    pulse_start(0);
    for (int n = 0; n < 300 && done_n[0] == 0; n++) begin
      rdy_v[0] = (n % 4 == 3);
      step();
    end
    rdy_v[0] = 1'b1;
    chk("t2_timeout", (done_n[0] > 0), 1);
    repeat (3) step();
    chk_beats("t2", bq0);
    chk("t2_stall_stable", stall_bad, 0);
    chk("t2_credit", (maxc <= 4), 1);
    chk("t2_done_n", done_n[0], 1);

    // Ready low for 20 cycles
    clear_mon();
    rdy_v[0] = 1'b0;
    pulse_start(0);
    repeat (20) step();
    chk("t3_strobes_held", str_n, 4);
    chk("t3_valid_full", mval_v[0], 1);
    chk("t3_credit_full", maxc, 4);
    chk("t3_no_hs", hs_n[0], 0);
    rdy_v[0] = 1'b1;
    wait_done(0, 100, "t3");
    repeat (3) step();
    chk_beats("t3", bq0);
    chk("t3_strobes", str_n, 8);
    chk("t3_done_n", done_n[0], 1);

    // MEM_LAT 1 and 8 sweep
    clear_mon();
    start_v[1] = 1'b1;
    start_v[2] = 1'b1;
    step();
    start_v[1] = 1'b0;
    start_v[2] = 1'b0;
    for (int n = 0; n < 300 && (done_n[1] == 0 || done_n[2] == 0); n++) step();
    repeat (3) step();
    chk_beats("t4_lat1", bq1);
    chk_beats("t4_lat8", bq2);
    chk("t4_lat1_done_n", done_n[1], 1);
    chk("t4_lat8_done_n", done_n[2], 1);
    chk("t4_lat1_hs_at_done", hs_at_done[1], 8);
    chk("t4_lat8_hs_at_done", hs_at_done[2], 8);

    // Second start at cycle 3 of a transfer
    clear_mon();
    pulse_start(0);
    step();
    step();
    pulse_start(0);
    wait_done(0, 100, "t5");
    repeat (6) step();
    chk("t5_done_n", done_n[0], 1);
    chk("t5_hs_n", hs_n[0], 8);
    chk("t5_strobes", str_n, 8);
    chk_beats("t5", bq0);

    // Reset after the third beat
    clear_mon();
    pulse_start(0);
    for (int n = 0; n < 100 && hs_n[0] < 3; n++) step();
    chk("t6_three_beats", hs_n[0], 3);
    nRST = 1'b0;
    #1;
    chk("t6_rst_busy", busy_v[0], 0);
    chk("t6_rst_rd_en", {are_v[0], bre_v[0]}, 0);
    chk("t6_rst_addr", {aaddr_v[0], baddr_v[0]}, 0);
    chk("t6_rst_valid", mval_v[0], 0);
    chk("t6_rst_stream", ms_v[0], 0);
    chk("t6_rst_done", done_v[0], 0);
    repeat (3) step();
    chk("t6_no_done", done_n[0], 0);
    nRST = 1'b1;
    step();
    clear_mon();
    pulse_start(0);
    wait_done(0, 100, "t6");
    repeat (3) step();
    chk_addrs("t6");
    chk_beats("t6", bq0);
    chk("t6_done_n", done_n[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sys_arr_in_streamer.md
Name: sys_arr_in_streamer

Overview:
- Upstream feeder for sys_array in streaming modes (SYS_MODE 0/1).
- Reads operand matrix A (M x N) and matrix B (N x K, K = M) from two fixed-latency banked memories.
- Packs A-column and B-row segments into interleaved BW-lane stream beats and presents them on a valid/ready stream to sys_array's input stream.
- Replaces the bench-driven push sequence with synthesizable address generation, latency tracking and buffering.

Parameters:
- BW, 128, stream lanes of 32-bit words; even, >= 2; L = BW/2 words per memory read.
- M, 64, rows of A = columns of B; multiple of L.
- N, 4, inner dimension.
- MEM_LAT, 3, fixed read latency in cycles from rd_en to rd_data valid; 1..8.
- FIFO_DEPTH, 4, beat buffer depth; >= 2, power of two.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a transfer when idle.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse after the last beat handshake.
- a_rd_en  output  1  A bank read strobe.
- a_rd_addr  output  $clog2(N*M/L)  A bank entry address.
- a_rd_data  input  L*32  A bank data; entry e holds L consecutive rows of one A column.
- b_rd_en  output  1  B bank read strobe; always equal to a_rd_en.
- b_rd_addr  output  $clog2(N*M/L)  B bank entry address.
- b_rd_data  input  L*32  B bank data; entry holds L consecutive columns of one B row.
- m_stream  output  BW*32  packed beat.
- m_valid  output  1  beat valid.
- m_ready  input  1  downstream ready.

Behaviour:
- Reset values: busy=0, done=0, a_rd_en=b_rd_en=0, addresses=0, m_valid=0, m_stream=0. FIFO is emptied and in-flight reads are discarded.
- Beat order:
  - Outer index k runs N-1 down to 0; inner index blk runs 0 .. M/L-1.
  - Total beats = N*M/L.
  - Beat address: a_rd_addr = b_rd_addr = k*(M/L) + blk.
- Packing: for i in 0..L-1:
  - m_stream lane 2i = a_rd_data word i.
  - m_stream lane 2i+1 = b_rd_data word i.
  - Lane j occupies bits [32j+31:32j].
- Latency tracking:
  - A MEM_LAT-deep valid shift register marks returning data.
  - Data is captured into the FIFO exactly MEM_LAT cycles after the strobe.
  - Memory data outside these cycles is ignored.
- Credit rule: issue a read only when (FIFO occupancy + outstanding reads) < FIFO_DEPTH. The FIFO therefore never overflows, and backpressure never drops data.
- Stream rule:
  - m_valid = FIFO not empty.
  - Beat handshake = m_valid & m_ready.
  - m_stream holds stable while m_valid & !m_ready.
  - A simultaneous capture and pop on the same cycle leaves occupancy unchanged.
  - With a full FIFO, a pop on the same cycle as a capture is legal. The credit rule makes a capture into a full FIFO without a pop impossible.
- FSM:
  - IDLE -> ISSUE on start. The addr counter loads k=N-1, blk=0; busy rises next cycle.
  - ISSUE: a strobe is issued whenever credit is available. blk increments and wraps to 0 at M/L-1 while k decrements. ISSUE -> DRAIN after the last strobe (k=0, blk=M/L-1).
  - DRAIN: waits for outstanding reads = 0, FIFO empty and total handshakes = N*M/L. DRAIN -> DONE.
  - DONE: done=1 for one cycle, busy=0, then -> IDLE.
- start while busy is ignored and does not restart.
- Reset mid-transfer aborts immediately to IDLE. There is no done pulse; the next start begins from k=N-1.
- With m_ready held high and MEM_LAT < FIFO_DEPTH: first m_valid appears MEM_LAT+2 cycles after start, and one beat is delivered per cycle thereafter.

Test Plan:
- BW=8 (L=4), M=8, N=4, MEM_LAT=3, m_ready=1, start pulse:
  - Required 8 strobes with addresses 6,7,4,5,2,3,0,1.
  - First m_valid 5 cycles after start.
  - Beat 0 lanes = {A[0][3], B[3][0], A[1][3], B[3][1], ...}.
  - done 1 cycle after the 8th handshake.
- Same config, m_ready toggling 1-of-4 cycles:
  - All 8 beats arrive in order, none duplicated or dropped.
  - m_stream is stable while stalled.
  - Outstanding reads + occupancy <= 4 on every cycle.
- m_ready=0 for 20 cycles after start:
  - Exactly 4 strobes are issued, then none.
  - FIFO full with m_valid=1.
  - Releasing m_ready drains all 8 beats in order.
- MEM_LAT=1 and MEM_LAT=8 sweeps with the same data: identical beat sequence; done asserts after exactly 8 handshakes.
- Second start pulsed at cycle 3 of a transfer: ignored; a single done pulse and 8 beats total.
- nRST low mid-transfer after beat 3:
  - All outputs return to reset values asynchronously; no done pulse.
  - A new start produces the full 8-beat sequence beginning at address 6.
